useq: RTL and testbench

Microcode sequencer for the SCAMP CPU. It owns the T-state counter and the opcode register, and it forms the microcode ROM address. It supplies the physical 16-bit microinstruction word to the combinational control decoder. It also provides fixed fetch steps, early termination on RT, memory/IO wait stalls, and a run/single-step halt handshake for the front panel.

---
 rtl/useq_pkg.sv | 39 +++
 rtl/useq_if.sv | 31 +++
 rtl/useq_halt.sv | 56 +++++
 rtl/useq.sv | 81 ++++++++
 tb/tb_useq.sv | 172 +++++++++++++++++
 5 files changed

// File: rtl/useq_pkg.sv
// Shared definitions for the SCAMP microcode sequencer: physical microword
// constants, control-decoder bit masks and halt controller state encodings.
package useq_pkg;

  localparam int OPW = 8;
  localparam int TW  = 3;

  localparam logic [15:0] FETCH0 = 16'h8020;
  localparam logic [15:0] FETCH1 = 16'hB440;
  localparam logic [15:0] NOP    = 16'h8000;

  // Bit 15 is the inverted EO sense; [7:5] is the bus-input select field.
  localparam logic [15:0] M_EO    = 16'h8000;
  localparam logic [15:0] M_EX    = 16'h2000;
  localparam logic [15:0] M_NX    = 16'h1000;
  localparam logic [15:0] M_EY    = 16'h0800;
  localparam logic [15:0] M_NY    = 16'h0400;
  localparam logic [15:0] M_F     = 16'h0200;
  localparam logic [15:0] M_NO    = 16'h0100;
  localparam logic [15:0] M_IN    = 16'h00E0;
  localparam logic [15:0] M_AI    = 16'h0020;
  localparam logic [15:0] M_II    = 16'h0040;
  localparam logic [15:0] M_XI    = 16'h0060;
  localparam logic [15:0] M_JZ    = 16'h0008;
  localparam logic [15:0] M_JGT   = 16'h0004;
  localparam logic [15:0] M_JLT   = 16'h0002;
  localparam logic [15:0] M_JC    = 16'h0001;

  typedef enum logic [1:0] {
    ST_RUN  = 2'd0,
    ST_HALT = 2'd1,
    ST_STEP = 2'd2
  } halt_state_e;

  function automatic logic is_ii(input logic [15:0] ui);
    return ((ui & M_IN) == M_II);
  endfunction

endpackage

// File: rtl/useq_if.sv
// Sequencer bus bundle: master is the CPU/panel side, slave is the sequencer.
interface useq_if
  import useq_pkg::*;
#(
  parameter int P_OPW = OPW,
  parameter int P_TW  = TW
);
  logic [15:0]          bus;
  logic [15:0]          urom_data;
  logic                 ii;
  logic                 rt;
  logic                 wait_req;
  logic                 ready;
  logic                 run;
  logic                 step;
  logic [P_OPW+P_TW-1:0] uaddr;
  logic [15:0]          uinstr;
  logic [P_TW-1:0]      tstate;
  logic                 halted;
  logic                 instr_done;

  modport master (
    output bus, urom_data, ii, rt, wait_req, ready, run, step,
    input  uaddr, uinstr, tstate, halted, instr_done
  );

  modport slave (
    input  bus, urom_data, ii, rt, wait_req, ready, run, step,
    output uaddr, uinstr, tstate, halted, instr_done
  );
endinterface

// File: rtl/useq_halt.sv
// Run / single-step controller; parks the sequencer at instruction boundaries.
module useq_halt
  import useq_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic i_boundary,
  input  logic i_run,
  input  logic i_step,
  output logic o_halted
);

  halt_state_e r_state;
  halt_state_e w_next;

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_HALT;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic; run outranks step, step is only honoured in HALT
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_RUN: begin
        if (i_boundary && !i_run) w_next = ST_HALT;
        else                      w_next = ST_RUN;
      end
      ST_HALT: begin
        if (i_run)       w_next = ST_RUN;
        else if (i_step) w_next = ST_STEP;
        else             w_next = ST_HALT;
      end
      ST_STEP: begin
        if (i_run)           w_next = ST_RUN;
        else if (i_boundary) w_next = ST_HALT;
        else                 w_next = ST_STEP;
      end
      default: w_next = ST_HALT;
    endcase
  end

  // Output decode
  always_comb begin
    o_halted = 1'b0;
    case (r_state)
      ST_HALT: o_halted = 1'b1;
      default: o_halted = 1'b0;
    endcase
  end

endmodule

// File: rtl/useq.sv
// SCAMP microcode sequencer: T-state counter, opcode register, ROM address
// formation and fetch-step injection, with wait stalls and run/step halting.
module useq
  import useq_pkg::*;
(
  input  logic  clk,
  input  logic  reset,
  useq_if.slave u
);

  localparam logic [TW-1:0] T_ZERO = {TW{1'b0}};
  localparam logic [TW-1:0] T_ONE  = {{(TW-1){1'b0}}, 1'b1};
  localparam logic [TW-1:0] T_LAST = {TW{1'b1}};

  logic [TW-1:0]  r_tstate;
  logic [OPW-1:0] r_opcode;
  logic           w_halted;
  logic           w_stall;
  logic           w_adv;
  logic           w_last;
  logic           w_boundary;
  logic [15:0]    w_uinstr;

  assign w_stall    = u.wait_req & ~u.ready & ~w_halted;
  assign w_adv      = ~w_halted & ~w_stall;
  assign w_last     = u.rt | (r_tstate == T_LAST);
  assign w_boundary = w_adv & w_last;

  useq_halt u_halt (
    .clk        (clk),
    .reset      (reset),
    .i_boundary (w_boundary),
    .i_run      (u.run),
    .i_step     (u.step),
    .o_halted   (w_halted)
  );

  // T-state counter: holds while stalled or halted, restarts on RT or T7
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_tstate <= T_ZERO;
    end else if (w_adv) begin
      if (w_last) r_tstate <= T_ZERO;
      else        r_tstate <= r_tstate + T_ONE;
    end else begin
      r_tstate <= r_tstate;
    end
  end

  // Opcode register; a stalled II must not capture a bus value that is not yet valid
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_opcode <= {OPW{1'b0}};
    end else if (w_adv && u.ii) begin
      r_opcode <= u.bus[15:8];
    end else begin
      r_opcode <= r_opcode;
    end
  end

  // Microword select: fixed fetch steps at T0/T1, ROM afterwards
  always_comb begin
    w_uinstr = NOP;
    if (w_halted) begin
      w_uinstr = NOP;
    end else begin
      case (r_tstate)
        T_ZERO:  w_uinstr = FETCH0;
        T_ONE:   w_uinstr = FETCH1;
        default: w_uinstr = u.urom_data;
      endcase
    end
  end

  assign u.uinstr     = w_uinstr;
  assign u.uaddr      = {r_opcode, r_tstate};
  assign u.tstate     = r_tstate;
  assign u.halted     = w_halted;
  assign u.instr_done = w_boundary;

endmodule

// File: tb/tb_useq.sv
// Directed, table-driven bench for the useq microcode sequencer.
module tb_useq;

  logic clk;
  logic reset;

  useq_if uif ();

  useq dut (
    .clk   (clk),
    .reset (reset),
    .u     (uif.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // II decoded from the microword's bus-input field (value 2 at bits [7:5])
  assign uif.ii = (uif.uinstr[7:5] == 3'd2);

  typedef struct {
    logic        run;
    logic        step;
    logic        rt;
    logic        wreq;
    logic        rdy;
    logic [15:0] bus;
    logic [2:0]  t;
    logic [15:0] ui;
    logic [10:0] ua;
    logic        done;
    logic        halt;
  } vec_t;

  vec_t vq[$];
  int   n_tests;
  int   n_fail;

  task automatic add(input logic run_i, input logic step_i, input logic rt_i,
                     input logic wreq_i, input logic rdy_i, input logic [15:0] bus_i,
                     input logic [2:0] t_i, input logic [15:0] ui_i, input logic [10:0] ua_i,
                     input logic done_i, input logic halt_i);
    vec_t v;
    v.run = run_i; v.step = step_i; v.rt = rt_i; v.wreq = wreq_i; v.rdy = rdy_i;
    v.bus = bus_i; v.t = t_i; v.ui = ui_i; v.ua = ua_i; v.done = done_i; v.halt = halt_i;
    vq.push_back(v);
  endtask

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, " tstate"}, 16'(uif.tstate), 16'h0000);
    check({tag, " uinstr"}, uif.uinstr, 16'h8000);
    check({tag, " uaddr"}, 16'(uif.uaddr), 16'h0000);
    check({tag, " halted"}, 16'(uif.halted), 16'h0001);
    check({tag, " instr_done"}, 16'(uif.instr_done), 16'h0000);
  endtask

  initial begin
    bit found;
    n_tests = 0;
    n_fail  = 0;

    //  run step rt wreq rdy bus       t  uinstr    uaddr    done halt
    add(1, 0, 0, 0, 1, 16'h1234, 0, 16'h8020, 11'h000, 0, 0);
    add(1, 0, 0, 0, 1, 16'h1234, 1, 16'hB440, 11'h001, 0, 0);
    add(1, 0, 0, 0, 1, 16'h1234, 2, 16'h8000, 11'h092, 0, 0);
    add(1, 1, 0, 0, 1, 16'h1234, 3, 16'h8000, 11'h093, 0, 0);
    add(1, 0, 0, 0, 1, 16'h1234, 4, 16'h8000, 11'h094, 0, 0);
    add(1, 0, 0, 0, 1, 16'h1234, 5, 16'h8000, 11'h095, 0, 0);
    add(1, 0, 0, 0, 1, 16'h1234, 6, 16'h8000, 11'h096, 0, 0);
    add(1, 0, 0, 0, 1, 16'h1234, 7, 16'h8000, 11'h097, 1, 0);
    add(1, 0, 0, 0, 1, 16'h1234, 0, 16'h8020, 11'h090, 0, 0);
    add(1, 0, 0, 0, 1, 16'h1234, 1, 16'hB440, 11'h091, 0, 0);
    add(1, 0, 0, 0, 1, 16'h1234, 2, 16'h8000, 11'h092, 0, 0);
    add(1, 0, 1, 0, 1, 16'h1234, 3, 16'h8000, 11'h093, 1, 0);
    add(1, 0, 0, 0, 1, 16'h1234, 0, 16'h8020, 11'h090, 0, 0);
    add(1, 0, 0, 1, 0, 16'hAB00, 1, 16'hB440, 11'h091, 0, 0);
    add(1, 0, 0, 1, 0, 16'hAB00, 1, 16'hB440, 11'h091, 0, 0);
    add(1, 0, 0, 1, 0, 16'hAB00, 1, 16'hB440, 11'h091, 0, 0);
    add(1, 0, 0, 1, 1, 16'hAB00, 1, 16'hB440, 11'h091, 0, 0);
    add(1, 0, 0, 0, 1, 16'hAB00, 2, 16'h8000, 11'h55A, 0, 0);
    add(1, 0, 0, 0, 1, 16'hAB00, 3, 16'h8000, 11'h55B, 0, 0);
    add(0, 0, 0, 0, 1, 16'hAB00, 4, 16'h8000, 11'h55C, 0, 0);
    add(0, 0, 0, 0, 1, 16'hAB00, 5, 16'h8000, 11'h55D, 0, 0);
    add(0, 0, 0, 0, 1, 16'hAB00, 6, 16'h8000, 11'h55E, 0, 0);
    add(0, 0, 0, 0, 1, 16'hAB00, 7, 16'h8000, 11'h55F, 1, 0);
    add(0, 0, 0, 0, 1, 16'hAB00, 0, 16'h8000, 11'h558, 0, 1);
    add(0, 1, 0, 0, 1, 16'hAB00, 0, 16'h8000, 11'h558, 0, 1);
    add(0, 0, 0, 0, 1, 16'hAB00, 0, 16'h8020, 11'h558, 0, 0);
    add(0, 0, 0, 0, 1, 16'hAB00, 1, 16'hB440, 11'h559, 0, 0);
    add(0, 0, 0, 0, 1, 16'hAB00, 2, 16'h8000, 11'h55A, 0, 0);
    add(0, 1, 0, 0, 1, 16'hAB00, 3, 16'h8000, 11'h55B, 0, 0);
    add(0, 0, 0, 0, 1, 16'hAB00, 4, 16'h8000, 11'h55C, 0, 0);
    add(0, 0, 0, 0, 1, 16'hAB00, 5, 16'h8000, 11'h55D, 0, 0);
    add(0, 0, 0, 0, 1, 16'hAB00, 6, 16'h8000, 11'h55E, 0, 0);
    add(0, 0, 0, 0, 1, 16'hAB00, 7, 16'h8000, 11'h55F, 1, 0);
    add(0, 0, 0, 0, 1, 16'hAB00, 0, 16'h8000, 11'h558, 0, 1);
    add(1, 1, 0, 0, 1, 16'hAB00, 0, 16'h8000, 11'h558, 0, 1);
    add(1, 0, 0, 0, 1, 16'hAB00, 0, 16'h8020, 11'h558, 0, 0);
    add(0, 1, 0, 0, 1, 16'hAB00, 1, 16'hB440, 11'h559, 0, 0);
    add(0, 0, 0, 0, 1, 16'hAB00, 2, 16'h8000, 11'h55A, 0, 0);
    add(0, 0, 0, 0, 1, 16'hAB00, 3, 16'h8000, 11'h55B, 0, 0);
    add(0, 0, 0, 0, 1, 16'hAB00, 4, 16'h8000, 11'h55C, 0, 0);
    add(0, 0, 0, 0, 1, 16'hAB00, 5, 16'h8000, 11'h55D, 0, 0);
    add(0, 0, 0, 0, 1, 16'hAB00, 6, 16'h8000, 11'h55E, 0, 0);
    add(0, 0, 0, 0, 1, 16'hAB00, 7, 16'h8000, 11'h55F, 1, 0);
    add(0, 0, 0, 0, 1, 16'hAB00, 0, 16'h8000, 11'h558, 0, 1);
    add(0, 0, 0, 0, 1, 16'hAB00, 0, 16'h8000, 11'h558, 0, 1);

    reset          = 1'b1;
    uif.run        = 1'b1;
    uif.step       = 1'b0;
    uif.rt         = 1'b0;
    uif.wait_req   = 1'b0;
    uif.ready      = 1'b1;
    uif.bus        = 16'h1234;
    uif.urom_data  = 16'h8000;

    repeat (2) @(negedge clk);
    #1;
    check_reset_vals("reset");

    @(negedge clk);
    reset = 1'b0;

    foreach (vq[i]) begin
      @(negedge clk);
      uif.run      = vq[i].run;
      uif.step     = vq[i].step;
      uif.rt       = vq[i].rt;
      uif.wait_req = vq[i].wreq;
      uif.ready    = vq[i].rdy;
      uif.bus      = vq[i].bus;
      #1;
      check($sformatf("v%0d tstate", i), 16'(uif.tstate), 16'(vq[i].t));
      check($sformatf("v%0d uinstr", i), uif.uinstr, vq[i].ui);
      check($sformatf("v%0d uaddr", i), 16'(uif.uaddr), 16'(vq[i].ua));
      check($sformatf("v%0d instr_done", i), 16'(uif.instr_done), 16'(vq[i].done));
      check($sformatf("v%0d halted", i), 16'(uif.halted), 16'(vq[i].halt));
    end

    // Reset in the middle of a running instruction must clear everything at once
    uif.run  = 1'b1;
    uif.step = 1'b0;
    uif.rt   = 1'b0;
    found    = 1'b0;
    for (int c = 0; c < 40 && !found; c++) begin
      @(negedge clk);
      #1;
      if (uif.tstate == 3'd5 && !uif.halted) found = 1'b1;
    end
    check("reach T5 before reset", 16'(found), 16'h0001);
    check("uaddr at T5", 16'(uif.uaddr), 16'h055D);
    #1;
    reset = 1'b1;
    #1;
    check_reset_vals("async reset");
    @(negedge clk);
    reset = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
